// File: rtl/work_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : work_ram_arbiter
// Purpose  : Single-port work/video RAM arbiter (video > CPU > hiscore) with
//            a CPU anti-starvation burst limit. The hiscore port is built in
//            only when HISCORE_PORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module work_ram_arbiter #(
    parameter int AW            = 13,
    parameter int DW            = 8,
    parameter int VID_BURST_MAX = 3
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
`ifdef HISCORE_PORT_EN
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_ack,
`endif
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] c_OWN_VID = 2'd0;
    localparam logic [1:0] c_OWN_CPU = 2'd1;
    localparam logic [1:0] c_OWN_HS  = 2'd2;
    localparam logic [2:0] c_VB_MAX  = 3'(VID_BURST_MAX);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_owner, w_gnt_owner;
    logic          r_acc_we;
    logic [2:0]    r_vburst;

    logic          r_vid_pend;
    logic [AW-1:0] r_vid_addr;
    logic          r_cpu_pend, r_cpu_we;
    logic [AW-1:0] r_cpu_addr;
    logic [DW-1:0] r_cpu_wdata;

    logic          w_hs_pend, w_hs_we;
    logic [AW-1:0] w_hs_addr;
    logic [DW-1:0] w_hs_wdata;

    logic          w_any_pend, w_decide, w_cpu_force, w_capture;

    assign w_any_pend  = r_vid_pend | r_cpu_pend | w_hs_pend;
    assign w_decide    = ((r_state == S_IDLE) || (r_state == S_CAPTURE)) && w_any_pend;
    assign w_cpu_force = r_cpu_pend && (r_vburst >= c_VB_MAX);
    assign w_capture   = (r_state == S_CAPTURE);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_owner = c_OWN_VID;
        case (r_state)
            S_IDLE:    if (w_any_pend) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = w_any_pend ? S_ISSUE : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (r_vid_pend && !w_cpu_force) w_gnt_owner = c_OWN_VID;
        else if (r_cpu_pend)            w_gnt_owner = c_OWN_CPU;
        else                            w_gnt_owner = c_OWN_HS;
    end

    // Grant edge loads the RAM port; ram_we self-clears after the ISSUE cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= c_OWN_VID;
            r_acc_we  <= 1'b0;
            r_vburst  <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            ram_we  <= 1'b0;
            if (w_decide) begin
                r_owner <= w_gnt_owner;
                case (w_gnt_owner)
                    c_OWN_CPU: begin
                        ram_addr  <= r_cpu_addr;
                        ram_we    <= r_cpu_we;
                        ram_wdata <= r_cpu_wdata;
                        r_acc_we  <= r_cpu_we;
                    end
                    c_OWN_HS: begin
                        ram_addr  <= w_hs_addr;
                        ram_we    <= w_hs_we;
                        ram_wdata <= w_hs_wdata;
                        r_acc_we  <= w_hs_we;
                    end
                    default: begin
                        ram_addr <= r_vid_addr;
                        r_acc_we <= 1'b0;
                    end
                endcase
            end
            if (!r_cpu_pend)
                r_vburst <= '0;
            else if (w_decide)
                r_vburst <= (w_gnt_owner == c_OWN_VID) ? r_vburst + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_vid_pend  <= 1'b0;
            r_vid_addr  <= '0;
            vid_overrun <= 1'b0;
            vid_valid   <= 1'b0;
            vid_data    <= '0;
            r_cpu_pend  <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_wdata <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            if (w_decide && (w_gnt_owner == c_OWN_VID)) begin
                r_vid_pend <= 1'b0;
            end else if (vid_req && !r_vid_pend) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= vid_addr;
            end
            if (vid_req && r_vid_pend) vid_overrun <= 1'b1;

            if (w_decide && (w_gnt_owner == c_OWN_CPU)) begin
                r_cpu_pend <= 1'b0;
            end else if (cpu_req && !r_cpu_pend) begin
                r_cpu_pend  <= 1'b1;
                r_cpu_we    <= cpu_we;
                r_cpu_addr  <= cpu_addr;
                r_cpu_wdata <= cpu_wdata;
            end

            vid_valid <= w_capture && (r_owner == c_OWN_VID);
            if (w_capture && (r_owner == c_OWN_VID)) vid_data <= ram_rdata;
            cpu_ack <= w_capture && (r_owner == c_OWN_CPU);
            if (w_capture && (r_owner == c_OWN_CPU) && !r_acc_we) cpu_rdata <= ram_rdata;
        end
    end

`ifdef HISCORE_PORT_EN
    logic          r_hs_pend, r_hs_we;
    logic [AW-1:0] r_hs_addr;
    logic [DW-1:0] r_hs_wdata;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hs_pend  <= 1'b0;
            r_hs_we    <= 1'b0;
            r_hs_addr  <= '0;
            r_hs_wdata <= '0;
            hs_ack     <= 1'b0;
            hs_rdata   <= '0;
        end else begin
            if (w_decide && (w_gnt_owner == c_OWN_HS)) begin
                r_hs_pend <= 1'b0;
            end else if (hs_req && !r_hs_pend) begin
                r_hs_pend  <= 1'b1;
                r_hs_we    <= hs_we;
                r_hs_addr  <= hs_addr;
                r_hs_wdata <= hs_wdata;
            end
            hs_ack <= w_capture && (r_owner == c_OWN_HS);
            if (w_capture && (r_owner == c_OWN_HS) && !r_acc_we) hs_rdata <= ram_rdata;
        end
    end

    assign w_hs_pend  = r_hs_pend;
    assign w_hs_we    = r_hs_we;
    assign w_hs_addr  = r_hs_addr;
    assign w_hs_wdata = r_hs_wdata;
`else
    assign w_hs_pend  = 1'b0;
    assign w_hs_we    = 1'b0;
    assign w_hs_addr  = '0;
    assign w_hs_wdata = '0;
`endif

endmodule
`default_nettype wire
